// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: owns the PC, absorbs the 1-cycle memory latency, holds on decode stall.
// Optional FETCH_ALIGN_CHECK_EN adds fetch_fault and a HALT state on misaligned redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] read_address,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_fault,
`endif
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
`ifdef FETCH_ALIGN_CHECK_EN
    HOLD = 2'd2,
    HALT = 2'd3
`else
    HOLD = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        advance_s;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
  logic        misaligned_s;
`endif

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      hold_instr_q <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_instr_q <= hold_instr_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q      <= fault_d;
`endif
    end
  end

  // Next-state logic: redirect > stall > advance; stall never blocks a FILL
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_instr_d = hold_instr_q;
    advance_s    = (state_q == FILL) || !stall;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d      = fault_q;
    misaligned_s = (redirect_target[1:0] != 2'b00);
    if (state_q == HALT) begin
      state_d = HALT;
    end else if (redirect_valid && misaligned_s) begin
      fault_d = 1'b1;
      state_d = HALT;
    end else
`endif
    if (redirect_valid) begin
      pc_d         = redirect_target & ~32'h0000_0003;
      hold_instr_d = 32'h0000_0000;
      state_d      = FILL;
    end else if (advance_s) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + STEP;
      state_d  = RUN;
    end else if (state_q == RUN) begin
      // Capture the word for req_pc before memory moves on to pc
      hold_instr_d = instruction;
      state_d      = HOLD;
    end else begin
      state_d = state_q;
    end
  end

  // Output decode
  always_comb begin
    if_valid       = 1'b0;
    if_instruction = 32'h0000_0000;
    case (state_q)
      RUN: begin
        if_valid       = 1'b1;
        if_instruction = instruction;
      end
      HOLD: begin
        if_valid       = 1'b1;
        if_instruction = hold_instr_q;
      end
      default: begin
        if_valid       = 1'b0;
        if_instruction = 32'h0000_0000;
      end
    endcase
  end

  assign read_address = pc_q;
  assign if_pc        = req_pc_q;
  assign if_pc_plus4  = req_pc_q + STEP;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault  = fault_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a registered big-endian memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] read_address;
  logic [31:0] instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .read_address    (read_address),
    .instruction     (instruction),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_fault     (fetch_fault),
`endif
    .if_valid        (if_valid),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'hAC0A_0004;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Registered-read instruction memory
  always @(posedge clk) instruction <= mem_word(read_address);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed vector: {if_valid, if_pc, if_instruction, read_address}
  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    step(); step();
    total_cnt++;
    if ({if_valid, if_pc, if_instruction, read_address} !== {1'b0, 32'h0, 32'h0, 32'h0})
      $display("FAIL reset_state: got v=%b pc=%h ins=%h ra=%h, want v=0 pc=0 ins=0 ra=0",
               if_valid, if_pc, if_instruction, read_address);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({if_valid, if_pc, if_instruction, read_address, if_pc_plus4} !==
          {1'b1, 32'(4*i), mem_word(32'(4*i)), 32'(4*i+4), 32'(4*i+4)})
        $display("FAIL seq_%0d: got v=%b pc=%h ins=%h ra=%h p4=%h", i,
                 if_valid, if_pc, if_instruction, read_address, if_pc_plus4);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    // Arrives here with if_pc=8, RUN
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({if_valid, if_pc, if_instruction, read_address} !== {1'b1, 32'h8, mem_word(32'h8), 32'hC})
        $display("FAIL stall_hold_%0d: got v=%b pc=%h ins=%h ra=%h, want pc=8 ins=%h ra=c", i,
                 if_valid, if_pc, if_instruction, read_address, mem_word(32'h8));
      else pass_cnt++;
      step();
    end
    stall = 1'b0;
    total_cnt++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h8, mem_word(32'h8)})
      $display("FAIL stall_hold_3: got pc=%h ins=%h", if_pc, if_instruction);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'(12+4*i), mem_word(32'(12+4*i))})
        $display("FAIL stall_release_%0d: got v=%b pc=%h ins=%h, want pc=%h", i,
                 if_valid, if_pc, if_instruction, 32'(12+4*i));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h4;
    step();
    redirect_valid = 1'b0;
    step();
    total_cnt++;
    if ({if_valid, if_pc, read_address} !== {1'b1, 32'h4, 32'h8})
      $display("FAIL redirect_to_4: got v=%b pc=%h ra=%h", if_valid, if_pc, read_address);
    else pass_cnt++;
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    total_cnt++;
    if ({if_valid, if_instruction, read_address} !== {1'b0, 32'h0, 32'h40})
      $display("FAIL redirect_bubble: got v=%b ins=%h ra=%h", if_valid, if_instruction, read_address);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_instruction, read_address} !== {1'b1, 32'h40, mem_word(32'h40), 32'h44})
      $display("FAIL redirect_target: got v=%b pc=%h ins=%h ra=%h",
               if_valid, if_pc, if_instruction, read_address);
    else pass_cnt++;
    step();
  endtask

  task automatic test_redirect_in_hold();
    // if_pc=0x44, RUN
    stall = 1'b1;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h44, mem_word(32'h44)})
      $display("FAIL hold_before_redir: got v=%b pc=%h ins=%h", if_valid, if_pc, if_instruction);
    else pass_cnt++;
    redirect_valid = 1'b1; redirect_target = 32'h80;
    step();
    redirect_valid = 1'b0;
    total_cnt++;
    if ({if_valid, if_instruction, read_address} !== {1'b0, 32'h0, 32'h80})
      $display("FAIL redir_stall_fill: got v=%b ins=%h ra=%h", if_valid, if_instruction, read_address);
    else pass_cnt++;
    step();
    stall = 1'b0;
    total_cnt++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h80, mem_word(32'h80)})
      $display("FAIL redir_stall_target: got v=%b pc=%h ins=%h", if_valid, if_pc, if_instruction);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    total_cnt++;
    if ({if_pc, if_pc_plus4, if_instruction, read_address} !==
        {32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0})
      $display("FAIL wrap_top: got pc=%h p4=%h ins=%h ra=%h", if_pc, if_pc_plus4, if_instruction, read_address);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_instruction, read_address} !== {1'b1, 32'h0, 32'hAC0A_0004, 32'h4})
      $display("FAIL wrap_zero: got v=%b pc=%h ins=%h ra=%h", if_valid, if_pc, if_instruction, read_address);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_hold();
    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_instruction, read_address} !== {1'b0, 32'h0, 32'h0, 32'h0})
      $display("FAIL reset_in_hold: got v=%b pc=%h ins=%h ra=%h", if_valid, if_pc, if_instruction, read_address);
    else pass_cnt++;
    reset = 1'b0; stall = 1'b0;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h0, 32'hAC0A_0004})
      $display("FAIL reset_recover: got v=%b pc=%h ins=%h", if_valid, if_pc, if_instruction);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    total_cnt++;
    if ({fetch_fault, if_valid, if_instruction} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL align_fault: got ff=%b v=%b ins=%h", fetch_fault, if_valid, if_instruction);
    else pass_cnt++;
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step(); step();
    redirect_valid = 1'b0;
    total_cnt++;
    if ({fetch_fault, if_valid, if_instruction} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL align_halt_sticky: got ff=%b v=%b ins=%h", fetch_fault, if_valid, if_instruction);
    else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if ({fetch_fault, if_valid, read_address} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL align_reset_clear: got ff=%b v=%b ra=%h", fetch_fault, if_valid, read_address);
    else pass_cnt++;
`else
    total_cnt++;
    if ({if_valid, read_address} !== {1'b0, 32'h40})
      $display("FAIL misaligned_clear: got v=%b ra=%h, want v=0 ra=40", if_valid, read_address);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h40, mem_word(32'h40)})
      $display("FAIL misaligned_target: got v=%b pc=%h ins=%h", if_valid, if_pc, if_instruction);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_in_hold();
    test_wrap();
    test_reset_in_hold();
    test_misaligned();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
